// File: rtl/s_axil_regbank_pkg.sv
// Shared response codes, address classes and the word-address decoder
// used by the AXI4-Lite register bank.
package s_axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    CLS_CTRL     = 2'd0,
    CLS_STAT     = 2'd1,
    CLS_UNMAPPED = 2'd2
  } addr_class_e;

  function automatic addr_class_e decode_addr(
    input logic [31:0] word_addr,
    input int unsigned n_ctrl,
    input int unsigned stat_base,
    input int unsigned n_stat
  );
    addr_class_e cls;
    if (word_addr < n_ctrl) begin
      cls = CLS_CTRL;
    end else if ((word_addr >= stat_base) && (word_addr < stat_base + n_stat)) begin
      cls = CLS_STAT;
    end else begin
      cls = CLS_UNMAPPED;
    end
    return cls;
  endfunction

endpackage

// File: rtl/s_axil_regbank_skid.sv
// One-entry skid buffer: passes a request straight through when the consumer
// takes it, otherwise parks it and drops ready until it is taken.
module axil_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_take
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
    end else if (r_full) begin
      if (i_take) begin
        r_full <= 1'b0;
      end
    end else if (i_valid && !i_take) begin
      r_full <= 1'b1;
    end
  end

  // Payload only matters while r_full is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!r_full && i_valid && !i_take) begin
      r_data <= i_data;
    end
  end

  assign o_ready = !r_full;
  assign o_valid = r_full || i_valid;
  assign o_data  = r_full ? r_data : i_data;

endmodule

// File: rtl/s_axil_regbank.sv
// AXI4-Lite register bank: N_CTRL read/write control registers with write
// pulses, N_STAT strobe-captured status registers with read pulses.
module s_axil_regbank
  import s_axil_regbank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned N_CTRL     = 8,
  parameter int unsigned N_STAT     = 8,
  parameter int unsigned STAT_BASE  = 16,
  parameter logic [N_CTRL*DATA_WIDTH-1:0] CTRL_INIT = '0
) (
  input  logic                           axi_clock,
  input  logic                           rst_n,

  input  logic [ADDR_WIDTH+1:0]          s_axil_awaddr,
  input  logic [2:0]                     s_axil_awprot,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,

  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,

  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,

  input  logic [ADDR_WIDTH+1:0]          s_axil_araddr,
  input  logic [2:0]                     s_axil_arprot,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,

  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,

  output logic [N_CTRL*DATA_WIDTH-1:0]   ctrl_regs,
  output logic [N_CTRL-1:0]              ctrl_wr_pulse,
  input  logic [N_STAT*DATA_WIDTH-1:0]   stat_data,
  input  logic [N_STAT-1:0]              stat_valid,
  output logic [N_STAT-1:0]              stat_rd_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned BA_W   = ADDR_WIDTH + 2;

  logic [DATA_WIDTH-1:0] r_ctrl [N_CTRL];
  logic [DATA_WIDTH-1:0] r_stat [N_STAT];
  logic [N_CTRL-1:0]     r_ctrl_wr_pulse;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [N_STAT-1:0]     r_rd_stat_sel;

  logic                         w_aw_valid;
  logic [BA_W-1:0]              w_aw_addr;
  logic                         w_w_valid;
  logic [DATA_WIDTH+STRB_W-1:0] w_w_bundle;
  logic [DATA_WIDTH-1:0]        w_wdata;
  logic [STRB_W-1:0]            w_wstrb;
  logic                         w_ar_valid;
  logic [BA_W-1:0]              w_ar_addr;
  logic [ADDR_WIDTH-1:0]        w_aw_word;
  logic [ADDR_WIDTH-1:0]        w_ar_word;
  addr_class_e                  w_wr_cls;
  addr_class_e                  w_ar_cls;
  logic                         w_wr_commit;
  logic                         w_rd_commit;
  logic [DATA_WIDTH-1:0]        w_rd_data;
  logic [N_STAT-1:0]            w_rd_stat_sel;
  logic                         w_unused_bits;

  axil_skid #(.WIDTH(BA_W)) u_aw_skid (
    .clk     (axi_clock),
    .rst_n   (rst_n),
    .i_valid (s_axil_awvalid),
    .o_ready (s_axil_awready),
    .i_data  (s_axil_awaddr),
    .o_valid (w_aw_valid),
    .o_data  (w_aw_addr),
    .i_take  (w_wr_commit)
  );

  axil_skid #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_skid (
    .clk     (axi_clock),
    .rst_n   (rst_n),
    .i_valid (s_axil_wvalid),
    .o_ready (s_axil_wready),
    .i_data  ({s_axil_wstrb, s_axil_wdata}),
    .o_valid (w_w_valid),
    .o_data  (w_w_bundle),
    .i_take  (w_wr_commit)
  );

  axil_skid #(.WIDTH(BA_W)) u_ar_skid (
    .clk     (axi_clock),
    .rst_n   (rst_n),
    .i_valid (s_axil_arvalid),
    .o_ready (s_axil_arready),
    .i_data  (s_axil_araddr),
    .o_valid (w_ar_valid),
    .o_data  (w_ar_addr),
    .i_take  (w_rd_commit)
  );

  assign w_wdata   = w_w_bundle[DATA_WIDTH-1:0];
  assign w_wstrb   = w_w_bundle[DATA_WIDTH +: STRB_W];
  assign w_aw_word = w_aw_addr[BA_W-1:2];
  assign w_ar_word = w_ar_addr[BA_W-1:2];
  assign w_wr_cls  = decode_addr(32'(w_aw_word), N_CTRL, STAT_BASE, N_STAT);
  assign w_ar_cls  = decode_addr(32'(w_ar_word), N_CTRL, STAT_BASE, N_STAT);

  // A request may only be consumed when its response slot is free or draining.
  assign w_wr_commit = w_aw_valid && w_w_valid && !(r_bvalid && !s_axil_bready);
  assign w_rd_commit = w_ar_valid && !(r_rvalid && !s_axil_rready);

  assign w_unused_bits = ^{s_axil_awprot, s_axil_arprot, w_aw_addr[1:0], w_ar_addr[1:0]};

  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CTRL; k++) begin
        r_ctrl[k] <= CTRL_INIT[k*DATA_WIDTH +: DATA_WIDTH];
      end
      r_ctrl_wr_pulse <= '0;
      r_bvalid        <= 1'b0;
      r_bresp         <= RESP_OKAY;
    end else begin
      r_ctrl_wr_pulse <= '0;
      if (w_wr_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_wr_cls == CLS_CTRL) ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < N_CTRL; k++) begin
          if (w_aw_word == ADDR_WIDTH'(k)) begin
            r_ctrl_wr_pulse[k] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (w_wstrb[b]) begin
                r_ctrl[k][b*8 +: 8] <= w_wdata[b*8 +: 8];
              end
            end
          end
        end
      end else if (s_axil_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Status space is read-only from the bus; only the strobes ever load it.
  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_STAT; k++) begin
        r_stat[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_STAT; k++) begin
        if (stat_valid[k]) begin
          r_stat[k] <= stat_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    w_rd_data     = '0;
    w_rd_stat_sel = '0;
    for (int k = 0; k < N_CTRL; k++) begin
      if (w_ar_word == ADDR_WIDTH'(k)) begin
        w_rd_data = r_ctrl[k];
      end
    end
    for (int k = 0; k < N_STAT; k++) begin
      if (w_ar_word == ADDR_WIDTH'(STAT_BASE + k)) begin
        w_rd_data        = r_stat[k];
        w_rd_stat_sel[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid      <= 1'b0;
      r_rresp       <= RESP_OKAY;
      r_rdata       <= '0;
      r_rd_stat_sel <= '0;
    end else if (w_rd_commit) begin
      r_rvalid      <= 1'b1;
      r_rresp       <= (w_ar_cls == CLS_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
      r_rdata       <= w_rd_data;
      r_rd_stat_sel <= w_rd_stat_sel;
    end else if (s_axil_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_CTRL; g++) begin : g_ctrl_out
    assign ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[g];
  end

  assign ctrl_wr_pulse = r_ctrl_wr_pulse;
  assign s_axil_bvalid = r_bvalid;
  assign s_axil_bresp  = r_bresp;
  assign s_axil_rvalid = r_rvalid;
  assign s_axil_rresp  = r_rresp;
  assign s_axil_rdata  = r_rdata;
  assign stat_rd_pulse = (r_rvalid && s_axil_rready) ? r_rd_stat_sel : '0;

endmodule
